// File: rtl/fib_pkg.sv
// Shared types and seed constants for the Fibonacci/Lucas engine.
// Imported by fib_step and fib_engine.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        FIB   = 1'b0,
        LUCAS = 1'b1
    } mode_t;

    localparam int FIB_SEED0   = 0;
    localparam int FIB_SEED1   = 1;
    localparam int LUCAS_SEED0 = 2;
    localparam int LUCAS_SEED1 = 1;

    // First seed (term 0) of the selected sequence.
    function automatic int seed0(input mode_t m);
        return (m == LUCAS) ? LUCAS_SEED0 : FIB_SEED0;
    endfunction

    // Second seed (term 1) of the selected sequence.
    function automatic int seed1(input mode_t m);
        return (m == LUCAS) ? LUCAS_SEED1 : FIB_SEED1;
    endfunction

endpackage

// File: rtl/fib_step.sv
// One recurrence step: sum = a + b with carry-out folded into a sticky
// overflow flag that also inherits the overflow state of both operands.
module fib_step
    import fib_pkg::*;
#(
    parameter int RES_W = 64
) (
    input  logic [RES_W-1:0] a,
    input  logic [RES_W-1:0] b,
    input  logic             ov_a,
    input  logic             ov_b,
    output logic [RES_W-1:0] sum,
    output logic             ov_sum
);

    logic carry;

    // Full-width add; the truncated sum is the term modulo 2^RES_W.
    always_comb begin
        {carry, sum} = {1'b0, a} + {1'b0, b};
        ov_sum       = carry | ov_a | ov_b;
    end

endmodule

// File: rtl/fib_engine.sv
// Iterative Fibonacci/Lucas term engine with valid/ready request and
// response handshakes and a sticky "true value exceeds RES_W" flag.
module fib_engine
    import fib_pkg::*;
#(
    parameter int N_W   = 8,
    parameter int RES_W = 64
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N_W-1:0]   req_n,
    input  logic             req_mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [RES_W-1:0] a_q;
    logic [RES_W-1:0] b_q;
    logic [RES_W-1:0] sum;
    logic             ov_a_q;
    logic             ov_b_q;
    logic             ov_sum;
    logic [N_W-1:0]   count_q;
    logic             accept;
    logic             last_step;
    mode_t            mode;

    assign mode      = mode_t'(req_mode);
    assign accept    = req_valid && req_ready;
    assign last_step = (count_q == N_W'(1));

    fib_step #(
        .RES_W (RES_W)
    ) u_step (
        .a      (a_q),
        .b      (b_q),
        .ov_a   (ov_a_q),
        .ov_b   (ov_b_q),
        .sum    (sum),
        .ov_sum (ov_sum)
    );

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: n = 0 skips CALC; DONE holds until handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (req_n != '0) ? CALC : DONE;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: seed on accept, advance the pair once per CALC cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            a_q     <= '0;
            b_q     <= '0;
            ov_a_q  <= 1'b0;
            ov_b_q  <= 1'b0;
            count_q <= '0;
        end else if (accept) begin
            a_q     <= RES_W'(seed0(mode));
            b_q     <= RES_W'(seed1(mode));
            ov_a_q  <= 1'b0;
            ov_b_q  <= 1'b0;
            count_q <= req_n;
        end else if (state_q == CALC) begin
            a_q     <= b_q;
            b_q     <= sum;
            ov_a_q  <= ov_b_q;
            ov_b_q  <= ov_sum;
            count_q <= count_q - N_W'(1);
        end
    end

    // Outputs decode registered state only; ready is masked in reset.
    always_comb begin
        req_ready    = (state_q == IDLE) && aresetn;
        rsp_valid    = (state_q == DONE);
        rsp_result   = (state_q == DONE) ? a_q : '0;
        rsp_overflow = (state_q == DONE) && ov_a_q;
        busy         = (state_q != IDLE);
    end

endmodule

// File: tb/tb_fib_engine.sv
// Directed self-checking bench for fib_engine (N_W=8, RES_W=64).
// Expected values are hand constants or a 192-bit exact reference.
module tb_fib_engine;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_n = '0;
    logic        req_mode = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_result;
    logic        rsp_overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fib_engine #(
        .N_W   (8),
        .RES_W (64)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_n        (req_n),
        .req_mode     (req_mode),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [191:0] obs,
                       input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Exact term n, wide enough that n=255 never truncates.
    function automatic logic [191:0] ref_term(input int n, input bit m);
        logic [191:0] a;
        logic [191:0] b;
        logic [191:0] t;
        a = m ? 192'd2 : 192'd0;
        b = 192'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Issue one request, wait (bounded) for the response, complete it.
    task automatic run(input int n, input bit m,
                       output logic [63:0] res, output logic ov,
                       output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1;
        req_n     = 8'(n);
        req_mode  = m;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        res = rsp_result;
        ov  = rsp_overflow;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [63:0]  res;
        logic         ov;
        int           lat;
        int           seen;
        logic [191:0] r;

        // Reset state
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_overflow", rsp_overflow, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);

        // rsp_ready while idle does nothing
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_rsp_ready_valid", rsp_valid, 0);
        chk("idle_rsp_ready_ready", req_ready, 1);

        // Directed vectors
        run(10, 1'b0, res, ov, lat);
        chk("fib10_res", res, 55);
        chk("fib10_ov", ov, 0);
        chk("fib10_lat", lat, 11);
        chk("after_hs_ready", req_ready, 1);

        run(10, 1'b1, res, ov, lat);
        chk("luc10_res", res, 123);
        chk("luc10_lat", lat, 11);

        run(0, 1'b0, res, ov, lat);
        chk("fib0_res", res, 0);
        chk("fib0_lat", lat, 1);

        run(0, 1'b1, res, ov, lat);
        chk("luc0_res", res, 2);
        chk("luc0_lat", lat, 1);

        run(93, 1'b0, res, ov, lat);
        chk("fib93_res", res, 64'd12200160415121876738);
        chk("fib93_ov", ov, 0);

        run(94, 1'b0, res, ov, lat);
        chk("fib94_res", res, 64'd1293530146158671551);
        chk("fib94_ov", ov, 1);

        // Stall response 20 cycles with a second request pending
        @(negedge clk);
        req_valid = 1'b1;
        req_n     = 8'd5;
        req_mode  = 1'b0;
        @(negedge clk);
        chk("stall_busy", busy, 1);
        req_n    = 8'd7;
        req_mode = 1'b1;
        seen = 0;
        while (!rsp_valid && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_result", rsp_result, 5);
            chk("stall_ov", rsp_overflow, 0);
            chk("stall_req_ready", req_ready, 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("stall_done_valid", rsp_valid, 0);
        chk("stall_done_ready", req_ready, 1);

        // Reset in the 5th CALC cycle of n=50
        req_valid = 1'b1;
        req_n     = 8'd50;
        req_mode  = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_calc_busy", busy, 1);
        aresetn = 1'b0;
        #1;
        chk("in_rst_ready", req_ready, 0);
        chk("in_rst_busy", busy, 0);
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        chk("rel_rst_ready", req_ready, 1);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no_rsp_after_rst", seen, 0);
        run(12, 1'b0, res, ov, lat);
        chk("fib12_after_rst", res, 144);
        chk("fib12_lat", lat, 13);

        // Sweep n=1..255 against the exact reference
        for (int n = 1; n < 256; n++) begin
            r = ref_term(n, 1'b0);
            run(n, 1'b0, res, ov, lat);
            chk($sformatf("sweep_res_%0d", n), res, r[63:0]);
            chk($sformatf("sweep_ov_%0d", n), ov, |r[191:64]);
            chk($sformatf("sweep_lat_%0d", n), lat, n + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
